// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from WIDTH JK flip-flop stages.
// The control logic turns load/count/hold requests into per-stage J/K inputs.

module jk_stage (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= (j & ~q) | (~k & q);
  end
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap
);
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             at_max, at_zero;
  logic [WIDTH-1:0] t_up, t_dn, lv;

  always_comb begin
    at_max  = (q == MAX);
    at_zero = (q == '0);
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    // A bit flips on increment when all lower bits are 1, on decrement when all are 0.
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
    lv = (load_val > MAX) ? MAX : load_val;
    tc = en & ~load & (up_dn ? at_max : at_zero);

    j_vec = '0;
    k_vec = '0;
    if (load) begin
      j_vec = lv;
      k_vec = ~lv;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          j_vec = '0;
          k_vec = '1;
        end else begin
          j_vec = t_up;
          k_vec = t_up;
        end
      end else begin
        if (at_zero) begin
          j_vec = MAX;
          k_vec = ~MAX;
        end else begin
          j_vec = t_dn;
          k_vec = t_dn;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= tc;
  end
endmodule
